// File: rtl/id_ex_stage.sv
// id_ex_stage: decode of OP/OP-IMM/LUI/AUIPC into a skid-buffered ALU issue register; ID_EX_PERF_EN adds perf counters
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctl,
    output logic            alu_ctl_ex,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_illegal
`endif
);
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      ctl;
        logic            ex;
        logic [4:0]      rd;
        logic            we;
        logic            ill;
    } ent_t;

    logic [6:0]      op, f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] d_a, d_b;
    logic [2:0]      d_ctl;
    logic            d_ex, d_ill;
    ent_t            dec, m, s;
    logic            m_valid, s_valid, m_free, in_xfer;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        d_a   = '0;
        d_b   = '0;
        d_ctl = f3;
        d_ex  = 1'b0;
        d_ill = 1'b0;
        case (op)
            7'b0110011: begin
                d_a   = rs1_data;
                d_b   = rs2_data;
                d_ex  = f7[5];
                d_ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            7'b0010011: begin
                d_a   = rs1_data;
                d_b   = {{(XLEN-12){instr[31]}}, instr[31:20]};
                d_ex  = (f3 == 3'b101) && f7[5];
                d_ill = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'b0110111: begin
                d_b   = {instr[31:12], 12'b0};
                d_ctl = 3'b000;
            end
            7'b0010111: begin
                d_a   = pc;
                d_b   = {instr[31:12], 12'b0};
                d_ctl = 3'b000;
            end
            default: d_ill = 1'b1;
        endcase
    end

    assign dec = '{a: d_ill ? '0 : d_a, b: d_ill ? '0 : d_b, ctl: d_ill ? 3'b000 : d_ctl,
                   ex: !d_ill && d_ex, rd: instr[11:7], we: !d_ill && |instr[11:7], ill: d_ill};

    assign m_free  = !m_valid || out_ready;
    assign in_xfer = in_valid && in_ready;

    // in_ready is kept equal to !s_valid so it comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            s_valid  <= 1'b0;
            in_ready <= 1'b1;
            m        <= '0;
            s        <= '0;
        end else if (flush) begin
            m_valid  <= 1'b0;
            s_valid  <= 1'b0;
            in_ready <= 1'b1;
        end else if (m_free) begin
            m_valid  <= s_valid || in_xfer;
            m        <= s_valid ? s : (in_xfer ? dec : m);
            s_valid  <= 1'b0;
            in_ready <= 1'b1;
        end else if (in_xfer) begin
            s        <= dec;
            s_valid  <= 1'b1;
            in_ready <= 1'b0;
        end
    end

    assign out_valid  = m_valid;
    assign alu_a      = m.a;
    assign alu_b      = m.b;
    assign alu_ctl    = m.ctl;
    assign alu_ctl_ex = m.ex;
    assign rd         = m.rd;
    assign rd_we      = m.we;
    assign illegal    = m.ill;

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued  <= '0;
            perf_stall   <= '0;
            perf_illegal <= '0;
        end else begin
            perf_issued  <= perf_issued + {31'b0, m_valid && out_ready};
            perf_stall   <= perf_stall + {31'b0, m_valid && !out_ready};
            perf_illegal <= perf_illegal + {31'b0, m_valid && out_ready && m.ill};
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage decode and skid-buffer handshake
module tb_id_ex_stage;
    logic        clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, alu_ctl_ex, rd_we, illegal;
    logic [31:0] instr = 0, pc = 0, rs1_data = 0, rs2_data = 0, alu_a, alu_b;
    logic [2:0]  alu_ctl;
    logic [4:0]  rd;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_issued, perf_stall, perf_illegal;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic        ex;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   pop_cyc[$];
    int   cyc = 0, tests = 0, fails = 0;
    exp_t act;
    assign act = {alu_a, alu_b, alu_ctl, alu_ctl_ex, rd, rd_we, illegal};

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctl(alu_ctl), .alu_ctl_ex(alu_ctl_ex), .rd(rd), .rd_we(rd_we), .illegal(illegal)
`ifdef ID_EX_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall), .perf_illegal(perf_illegal)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out got %h required no output", act);
            end else begin
                if (act !== q[0]) begin
                    fails++;
                    $display("FAIL out_payload got %h required %h", act, q[0]);
                end
                void'(q.pop_front());
                pop_cyc.push_back(cyc);
            end
        end
    end

    function automatic exp_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] c, logic x,
                                logic [4:0] r, logic w, logic i);
        return {a, b, c, x, r, w, i};
    endfunction

    task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                        input logic [31:0] r2, input exp_t e);
        int n = 0;
        instr = i; pc = p; rs1_data = r1; rs2_data = r2; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout instr=%h in_ready got 0 required 1", i);
        end else q.push_back(e);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending got %0d required 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({out_valid, in_ready} !== 2'b01 || act !== '0) begin
            fails++;
            $display("FAIL reset_state got v=%b r=%b %h required v=0 r=1 0", out_valid, in_ready, act);
        end
`ifdef ID_EX_PERF_EN
        tests++;
        if ({perf_issued, perf_stall, perf_illegal} !== '0) begin
            fails++;
            $display("FAIL reset_perf got %h %h %h required 0", perf_issued, perf_stall, perf_illegal);
        end
`endif
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_sub();
        out_ready = 1;
        send(32'h402081B3, 0, 10, 3, mk(10, 3, 3'b000, 1, 3, 1, 0));
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL sub_latency out_valid got %b required 1", out_valid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1;
        pop_cyc.delete();
        send(32'hFFF00293, 0, 0, 0, mk(0, 32'hFFFFFFFF, 3'b000, 0, 5, 1, 0));
        send(32'h4030D213, 0, 32'h80000000, 0, mk(32'h80000000, 32'h403, 3'b101, 1, 4, 1, 0));
        drain();
        tests++;
        if (pop_cyc.size() != 2 || pop_cyc[1] - pop_cyc[0] != 1) begin
            fails++;
            $display("FAIL back_to_back issues got %0d gap %0d required 2 gap 1", pop_cyc.size(),
                     pop_cyc.size() == 2 ? pop_cyc[1] - pop_cyc[0] : -1);
        end
    endtask

    task automatic test_upper_and_misc();
        out_ready = 1;
        send(32'h123450B7, 32'h40, 32'h55, 32'h66, mk(0, 32'h12345000, 3'b000, 0, 1, 1, 0));
        send(32'h00001117, 32'h100, 32'h55, 32'h66, mk(32'h100, 32'h1000, 3'b000, 0, 2, 1, 0));
        send(32'h009463B3, 0, 32'hF0, 32'h0F, mk(32'hF0, 32'h0F, 3'b110, 0, 7, 1, 0));
        send(32'h00208033, 0, 5, 7, mk(5, 7, 3'b000, 0, 0, 0, 0));
        send(32'h401091B3, 0, 1, 2, mk(0, 0, 3'b000, 0, 3, 0, 1));
        send(32'h40009093, 0, 1, 2, mk(0, 0, 3'b000, 0, 1, 0, 1));
        drain();
    endtask

    task automatic test_stall();
        out_ready = 0;
        send(32'h00100093, 0, 0, 0, mk(0, 1, 3'b000, 0, 1, 1, 0));
        send(32'h0FF0F113, 0, 32'h1234, 0, mk(32'h1234, 32'hFF, 3'b111, 0, 2, 1, 0));
        fork
            send(32'h0020D333, 0, 32'h80, 4, mk(32'h80, 4, 3'b101, 0, 6, 1, 0));
            begin
                repeat (3) begin
                    @(negedge clk);
                    tests++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || act !== q[0]) begin
                        fails++;
                        $display("FAIL stall_hold got r=%b v=%b %h required r=0 v=1 %h",
                                 in_ready, out_valid, act, q[0]);
                    end
                end
                @(posedge clk); #1 out_ready = 1;
            end
        join
        drain();
    endtask

    task automatic test_illegal();
`ifdef ID_EX_PERF_EN
        logic [31:0] b_ill, b_iss;
        b_ill = perf_illegal;
        b_iss = perf_issued;
`endif
        out_ready = 1;
        send(32'h0000007F, 0, 9, 9, mk(0, 0, 3'b000, 0, 0, 0, 1));
        drain();
`ifdef ID_EX_PERF_EN
        tests++;
        if (perf_illegal - b_ill !== 32'd1 || perf_issued - b_iss !== 32'd1) begin
            fails++;
            $display("FAIL perf_counts got ill+%0d iss+%0d required +1 +1",
                     perf_illegal - b_ill, perf_issued - b_iss);
        end
`endif
    endtask

    task automatic test_flush();
        out_ready = 0;
        send(32'h00100093, 0, 0, 0, mk(0, 1, 3'b000, 0, 1, 1, 0));
        send(32'h0FF0F113, 0, 32'h1234, 0, mk(32'h1234, 32'hFF, 3'b111, 0, 2, 1, 0));
        flush = 1; in_valid = 1; instr = 32'h0020D333;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        q.delete();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_state got v=%b r=%b required v=0 r=1", out_valid, in_ready);
        end
        out_ready = 1;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        send(32'h123450B7, 0, 0, 0, mk(0, 32'h12345000, 3'b000, 0, 1, 1, 0));
        drain();
    endtask

    initial begin
        test_reset();
        test_sub();
        test_back_to_back();
        test_upper_and_misc();
        test_stall();
        test_illegal();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
